// File: rtl/dma_w_ram_reader_if.sv
// Bus bundle for the OCM->external DMA write reader: descriptor, DMA write request,
// OCM read port and outgoing beat stream.
interface dma_w_ram_reader_if #(
   parameter int AXI_DW = 128
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [31:0]       cfg_src_sa;
   logic [31:0]       cfg_dst_sa;
   logic [31:0]       cfg_len;
   logic              dmaw_valid;
   logic              dmaw_ready;
   logic [31:0]       dmaw_sa;
   logic [31:0]       dmaw_len;
   logic              ram_re;
   logic [31:0]       ram_a;
   logic [AXI_DW-1:0] ram_q;
   logic [AXI_DW-1:0] dma_wdata;
   logic              dma_wlast;
   logic              dma_wvalid;
   logic              dma_wready;

   // Reader side: owns the request, RAM address and beat stream.
   modport master (
      input  cfg_valid, cfg_src_sa, cfg_dst_sa, cfg_len, dmaw_ready, ram_q, dma_wready,
      output cfg_ready, dmaw_valid, dmaw_sa, dmaw_len, ram_re, ram_a,
             dma_wdata, dma_wlast, dma_wvalid
   );

   modport slave (
      output cfg_valid, cfg_src_sa, cfg_dst_sa, cfg_len, dmaw_ready, ram_q, dma_wready,
      input  cfg_ready, dmaw_valid, dmaw_sa, dmaw_len, ram_re, ram_a,
             dma_wdata, dma_wlast, dma_wvalid
   );
endinterface

// File: rtl/dma_w_ram_reader.sv
// DMA write path reader: takes one descriptor, issues the DMA write request, then streams
// OCM words through a small show-ahead prefetch buffer as a valid/ready beat stream.
module dma_w_ram_reader #(
   parameter int AXI_DW    = 128,
   parameter int BUF_DEPTH = 4
) (
   input logic             usr_clk,
   input logic             usr_reset,
   dma_w_ram_reader_if.master bus
);
   localparam int BPB     = AXI_DW / 8;
   localparam int BPB_LOG = $clog2(BPB);
   localparam int PTR_W   = $clog2(BUF_DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      XFER
   } state_t;

   state_t            state, state_nxt;
   logic [31:0]       dst_sa, len, base_a, nbeats, rd_idx, tx_idx, ram_a_hold;
   logic              inflight;
   logic [AXI_DW-1:0] buf_mem [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              cfg_ready, dmaw_valid, rd_en, wvalid, wlast;
   logic              cfg_hs, beat_hs;
   logic [31:0]       nbeats_cfg;

   // ceil(len/BPB) without a carry out of 32 bits.
   assign nbeats_cfg = (bus.cfg_len >> BPB_LOG) + 32'(|bus.cfg_len[BPB_LOG-1:0]);

   assign cfg_hs  = bus.cfg_valid & cfg_ready;
   assign beat_hs = wvalid & bus.dma_wready;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt  = state;
      cfg_ready  = 1'b0;
      dmaw_valid = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            if (bus.cfg_valid && bus.cfg_len != 32'd0) state_nxt = CMD;
         end
         CMD: begin
            dmaw_valid = 1'b1;
            if (bus.dmaw_ready) state_nxt = XFER;
         end
         XFER: begin
            if (beat_hs && wlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Credit counts both buffered words and the read still in the RAM pipeline.
   assign rd_en  = (state != IDLE) && (rd_idx < nbeats) &&
                   (32'(count) + 32'(inflight) < 32'(BUF_DEPTH));
   assign wvalid = (state == XFER) && (count != '0);
   assign wlast  = wvalid && (tx_idx == nbeats - 32'd1);

   assign bus.cfg_ready  = cfg_ready;
   assign bus.dmaw_valid = dmaw_valid;
   assign bus.dmaw_sa    = dst_sa;
   assign bus.dmaw_len   = len;
   assign bus.ram_re     = rd_en;
   assign bus.ram_a      = rd_en ? base_a + rd_idx : ram_a_hold;
   assign bus.dma_wvalid = wvalid;
   assign bus.dma_wlast  = wlast;
   assign bus.dma_wdata  = wvalid ? buf_mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge usr_clk) begin
      if (usr_reset) begin
         state      <= IDLE;
         dst_sa     <= '0;
         len        <= '0;
         base_a     <= '0;
         nbeats     <= '0;
         rd_idx     <= '0;
         tx_idx     <= '0;
         ram_a_hold <= '0;
         inflight   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= rd_en;
         if (cfg_hs) begin
            dst_sa <= bus.cfg_dst_sa;
            len    <= bus.cfg_len;
            base_a <= bus.cfg_src_sa >> BPB_LOG;
            nbeats <= nbeats_cfg;
            rd_idx <= '0;
            tx_idx <= '0;
         end
         if (rd_en) begin
            rd_idx     <= rd_idx + 32'd1;
            ram_a_hold <= base_a + rd_idx;
         end
         if (inflight) wr_ptr <= wr_ptr + PTR_W'(1);
         if (beat_hs) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            tx_idx <= tx_idx + 32'd1;
         end
         if (inflight && !beat_hs)      count <= count + CNT_W'(1);
         else if (!inflight && beat_hs) count <= count - CNT_W'(1);
      end
   end

   // NOTE: buffer storage is not reset; occupancy is, and dma_wdata is gated by wvalid.
   always_ff @(posedge usr_clk) begin
      if (inflight) buf_mem[wr_ptr] <= bus.ram_q;
   end
endmodule
